// File: rtl/fifo_v4_mc.sv
// fifo_v4_mc: NUM_CH independent FIFO queues behind one push port, drained by a round-robin pop port.
// Optional build macro FIFO_V4_MC_PEAK_EN adds per-channel high-water marks on peak_usage_o.
module fifo_v4_mc #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned AF_TH        = DEPTH - 1,
  parameter int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       flush_i,
  input  logic                    push_valid_i,
  input  logic [CH_W-1:0]         push_ch_i,
  input  logic [DATA_WIDTH-1:0]   push_data_i,
  output logic                    push_ready_o,
  output logic                    pop_valid_o,
  output logic [CH_W-1:0]         pop_ch_o,
  output logic [DATA_WIDTH-1:0]   pop_data_o,
  input  logic                    pop_ready_i,
  output logic [NUM_CH-1:0]       full_o,
  output logic [NUM_CH-1:0]       empty_o,
  output logic [NUM_CH-1:0]       almost_full_o,
`ifdef FIFO_V4_MC_PEAK_EN
  output logic [NUM_CH*CNT_W-1:0] peak_usage_o,
`endif
  output logic [NUM_CH*CNT_W-1:0] usage_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [NUM_CH][DEPTH];
  logic [PTR_W-1:0]      wptr_q  [NUM_CH];
  logic [PTR_W-1:0]      wptr_d  [NUM_CH];
  logic [PTR_W-1:0]      rptr_q  [NUM_CH];
  logic [PTR_W-1:0]      rptr_d  [NUM_CH];
  logic [CNT_W-1:0]      usage_q [NUM_CH];
  logic [CNT_W-1:0]      usage_d [NUM_CH];
  logic [NUM_CH-1:0]     full_q, full_d, empty_q, empty_d, af_q, af_d;
  logic [CH_W-1:0]       rr_q, rr_d, lock_ch_q, lock_ch_d;
  logic                  lock_q, lock_d;
`ifdef FIFO_V4_MC_PEAK_EN
  logic [CNT_W-1:0]      peak_q [NUM_CH];
  logic [CNT_W-1:0]      peak_d [NUM_CH];
`endif

  logic                  push_acc_s, pop_acc_s, found_s, ft_head_s, ft_pop_s;
  logic [CH_W-1:0]       grant_s;
  logic [NUM_CH-1:0]     elig_s, wr_en_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Push acceptance: depends only on the target channel state, never on the pop side.
  always_comb begin
    push_ready_o = 1'b0;
    if (int'(push_ch_i) < int'(NUM_CH)) begin
      push_ready_o = !full_q[push_ch_i] && !flush_i[push_ch_i] && !rst_i;
    end else begin
      push_ready_o = 1'b0;
    end
    push_acc_s = push_valid_i && push_ready_o;
  end

  // Round-robin search from rr_q unless a stalled grant is held.
  always_comb begin
    int idx;
    idx     = 0;
    found_s = 1'b0;
    grant_s = rr_q;
    elig_s  = {NUM_CH{1'b0}};
    for (int c = 0; c < int'(NUM_CH); c++) begin
      elig_s[c] = !flush_i[c] &&
                  (!empty_q[c] || (FALL_THROUGH && push_acc_s && (int'(push_ch_i) == c)));
    end
    if (lock_q) begin
      grant_s = lock_ch_q;
      found_s = !flush_i[lock_ch_q];
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        idx = int'(rr_q) + i;
        if (idx >= int'(NUM_CH)) begin
          idx = idx - int'(NUM_CH);
        end else begin
          idx = idx;
        end
        if (!found_s && elig_s[idx]) begin
          found_s = 1'b1;
          grant_s = CH_W'(idx);
        end else begin
          found_s = found_s;
        end
      end
    end
  end

  // Pop presentation; an empty granted channel can only be a same-cycle bypass.
  always_comb begin
    pop_valid_o = found_s && !rst_i;
    pop_ch_o    = {CH_W{1'b0}};
    pop_data_o  = {DATA_WIDTH{1'b0}};
    ft_head_s   = FALL_THROUGH && empty_q[grant_s];
    if (pop_valid_o) begin
      pop_ch_o   = grant_s;
      pop_data_o = ft_head_s ? push_data_i : mem_q[grant_s][rptr_q[grant_s]];
    end else begin
      pop_ch_o   = {CH_W{1'b0}};
    end
    pop_acc_s = pop_valid_o && pop_ready_i;
    ft_pop_s  = pop_acc_s && ft_head_s;
  end

  // Per-channel pointer, usage and flag next-state.
  always_comb begin
    logic hit_push, hit_pop, rd;
    hit_push = 1'b0;
    hit_pop  = 1'b0;
    rd       = 1'b0;
    wr_en_s  = {NUM_CH{1'b0}};
    full_d   = {NUM_CH{1'b0}};
    empty_d  = {NUM_CH{1'b0}};
    af_d     = {NUM_CH{1'b0}};
    for (int c = 0; c < int'(NUM_CH); c++) begin
      hit_push   = push_acc_s && (int'(push_ch_i) == c);
      hit_pop    = pop_acc_s && (int'(grant_s) == c);
      wr_en_s[c] = hit_push && !(ft_pop_s && hit_pop);
      rd         = hit_pop && !ft_pop_s;
      if (flush_i[c]) begin
        wptr_d[c]  = {PTR_W{1'b0}};
        rptr_d[c]  = {PTR_W{1'b0}};
        usage_d[c] = {CNT_W{1'b0}};
      end else begin
        wptr_d[c]  = wr_en_s[c] ? ptr_inc(wptr_q[c]) : wptr_q[c];
        rptr_d[c]  = rd ? ptr_inc(rptr_q[c]) : rptr_q[c];
        usage_d[c] = usage_q[c] + CNT_W'(wr_en_s[c]) - CNT_W'(rd);
      end
      full_d[c]  = (usage_d[c] == CNT_W'(DEPTH));
      empty_d[c] = (usage_d[c] == {CNT_W{1'b0}});
      af_d[c]    = (usage_d[c] >= CNT_W'(AF_TH));
`ifdef FIFO_V4_MC_PEAK_EN
      if (flush_i[c]) begin
        peak_d[c] = {CNT_W{1'b0}};
      end else begin
        peak_d[c] = (usage_d[c] > peak_q[c]) ? usage_d[c] : peak_q[c];
      end
`endif
    end
  end

  // Arbiter pointer and grant lock next-state; a flush of the held channel drops the lock.
  always_comb begin
    rr_d      = rr_q;
    lock_d    = lock_q;
    lock_ch_d = lock_ch_q;
    if (pop_acc_s) begin
      rr_d = (int'(grant_s) == int'(NUM_CH) - 1) ? {CH_W{1'b0}} : grant_s + CH_W'(1);
    end else begin
      rr_d = rr_q;
    end
    if (lock_q && flush_i[lock_ch_q]) begin
      lock_d = 1'b0;
    end else if (pop_valid_o && !pop_ready_i) begin
      lock_d    = 1'b1;
      lock_ch_d = grant_s;
    end else if (pop_acc_s) begin
      lock_d = 1'b0;
    end else begin
      lock_d = lock_q;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        wptr_q[c]  <= {PTR_W{1'b0}};
        rptr_q[c]  <= {PTR_W{1'b0}};
        usage_q[c] <= {CNT_W{1'b0}};
`ifdef FIFO_V4_MC_PEAK_EN
        peak_q[c]  <= {CNT_W{1'b0}};
`endif
      end
      full_q    <= {NUM_CH{1'b0}};
      empty_q   <= {NUM_CH{1'b1}};
      af_q      <= {NUM_CH{1'b0}};
      rr_q      <= {CH_W{1'b0}};
      lock_q    <= 1'b0;
      lock_ch_q <= {CH_W{1'b0}};
    end else begin
      for (int c = 0; c < int'(NUM_CH); c++) begin
        wptr_q[c]  <= wptr_d[c];
        rptr_q[c]  <= rptr_d[c];
        usage_q[c] <= usage_d[c];
`ifdef FIFO_V4_MC_PEAK_EN
        peak_q[c]  <= peak_d[c];
`endif
      end
      full_q    <= full_d;
      empty_q   <= empty_d;
      af_q      <= af_d;
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
    end
  end

  // Payload storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (wr_en_s[c]) begin
        mem_q[c][wptr_q[c]] <= push_data_i;
      end
    end
  end

  // Flatten per-channel counters onto the output buses.
  always_comb begin
    usage_o = {(NUM_CH*CNT_W){1'b0}};
`ifdef FIFO_V4_MC_PEAK_EN
    peak_usage_o = {(NUM_CH*CNT_W){1'b0}};
`endif
    for (int c = 0; c < int'(NUM_CH); c++) begin
      usage_o[c*CNT_W +: CNT_W] = usage_q[c];
`ifdef FIFO_V4_MC_PEAK_EN
      peak_usage_o[c*CNT_W +: CNT_W] = peak_q[c];
`endif
    end
  end

  assign full_o        = full_q;
  assign empty_o       = empty_q;
  assign almost_full_o = af_q;

endmodule

// File: tb/tb_fifo_v4_mc.sv
// Directed scoreboard bench for fifo_v4_mc: u0 uses FALL_THROUGH=0, u1 uses FALL_THROUGH=1.
module tb_fifo_v4_mc;

  logic        clk;
  logic        rst;
  logic [3:0]  flush;
  logic        pv, prdy, ov, ordy;
  logic [1:0]  pch, och;
  logic [31:0] pdata, odata;
  logic [3:0]  full, empty, af;
  logic [15:0] usage, peak;

  logic        f_pv, f_prdy, f_ov, f_ordy;
  logic [1:0]  f_pch, f_och;
  logic [31:0] f_pdata, f_odata;
  logic [3:0]  f_full, f_empty, f_af;
  logic [15:0] f_usage, f_peak;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] sb [4][$];

  fifo_v4_mc u0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .push_valid_i(pv), .push_ch_i(pch), .push_data_i(pdata), .push_ready_o(prdy),
    .pop_valid_o(ov), .pop_ch_o(och), .pop_data_o(odata), .pop_ready_i(ordy),
    .full_o(full), .empty_o(empty), .almost_full_o(af),
`ifdef FIFO_V4_MC_PEAK_EN
    .peak_usage_o(peak),
`endif
    .usage_o(usage)
  );

  fifo_v4_mc #(.FALL_THROUGH(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .flush_i(4'b0000),
    .push_valid_i(f_pv), .push_ch_i(f_pch), .push_data_i(f_pdata), .push_ready_o(f_prdy),
    .pop_valid_o(f_ov), .pop_ch_o(f_och), .pop_data_o(f_odata), .pop_ready_i(f_ordy),
    .full_o(f_full), .empty_o(f_empty), .almost_full_o(f_af),
`ifdef FIFO_V4_MC_PEAK_EN
    .peak_usage_o(f_peak),
`endif
    .usage_o(f_usage)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] u_of(input logic [15:0] v, input int c);
    return v[c*4 +: 4];
  endfunction

  task automatic push0(input logic [1:0] ch, input logic [31:0] d);
    pv = 1'b1; pch = ch; pdata = d;
    #1;
    chk("push_ready", 64'(prdy), 64'd1);
    sb[ch].push_back(d);
    cyc();
    pv = 1'b0;
  endtask

  task automatic pop0(input logic [1:0] ch);
    logic [31:0] e;
    e = 32'd0;
    ordy = 1'b1;
    #1;
    if (sb[ch].size() > 0) e = sb[ch].pop_front();
    chk("pop_valid", 64'(ov), 64'd1);
    chk("pop_ch", 64'(och), 64'(ch));
    chk("pop_data", 64'(odata), 64'(e));
    cyc();
    ordy = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 4'b0000; pv = 1'b0; pch = 2'd0; pdata = 32'd0; ordy = 1'b0;
    f_pv = 1'b0; f_pch = 2'd0; f_pdata = 32'd0; f_ordy = 1'b0;
    cyc(); cyc();

    // reset state
    chk("rst_push_ready", 64'(prdy), 64'd0);
    chk("rst_empty", 64'(empty), 64'hF);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_af", 64'(af), 64'h0);
    chk("rst_pop_valid", 64'(ov), 64'd0);
    chk("rst_pop_ch", 64'(och), 64'd0);
    chk("rst_pop_data", 64'(odata), 64'd0);
    chk("rst_usage", 64'(usage), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 64'(prdy), 64'd1);
`ifdef FIFO_V4_MC_PEAK_EN
    chk("rst_peak", 64'(peak), 64'd0);
`endif

    // fill ch2 to the watermark and to full
    for (int i = 0; i < 8; i++) begin
      pv = 1'b1; pch = 2'd2; pdata = 32'h10 + 32'(i);
      #1;
      chk("fill_ready", 64'(prdy), 64'd1);
      if (i == 0) chk("nft_same_cycle", 64'(ov), 64'd0);
      sb[2].push_back(pdata);
      cyc();
      pv = 1'b0;
      #1;
      if (i == 0) chk("nft_latency1", 64'(ov), 64'd1);
      chk("fill_af", 64'(af[2]), 64'(i >= 6));
      chk("fill_full", 64'(full[2]), 64'(i == 7));
      chk("fill_usage", 64'(u_of(usage, 2)), 64'(i + 1));
    end
    pv = 1'b1; pch = 2'd2; pdata = 32'hFF;
    #1;
    chk("full_ready_ch2", 64'(prdy), 64'd0);
    cyc();
    pv = 1'b0;
    #1;
    chk("full_push_blocked", 64'(u_of(usage, 2)), 64'd8);
    pch = 2'd0;
    #1;
    chk("ready_ch0", 64'(prdy), 64'd1);
    chk("held_head_ch", 64'(och), 64'd2);
    chk("held_head_data", 64'(odata), 64'h10);
`ifdef FIFO_V4_MC_PEAK_EN
    chk("peak_ch2", 64'(u_of(peak, 2)), 64'd8);
`endif
    for (int i = 0; i < 8; i++) pop0(2'd2);
    #1;
    chk("drain_empty", 64'(empty), 64'hF);
    chk("drain_valid", 64'(ov), 64'd0);

    // round robin
    push0(2'd0, 32'hA); push0(2'd0, 32'hB); push0(2'd1, 32'hC);
    pop0(2'd0); pop0(2'd1); pop0(2'd0);
    #1;
    chk("rr_valid_low", 64'(ov), 64'd0);
    chk("rr_empty", 64'(empty), 64'hF);

    // stall stability
    push0(2'd3, 32'h55);
    for (int k = 0; k < 3; k++) begin
      pv = 1'b1; pch = 2'd0; pdata = 32'h60 + 32'(k);
      #1;
      chk("stall_valid", 64'(ov), 64'd1);
      chk("stall_ch", 64'(och), 64'd3);
      chk("stall_data", 64'(odata), 64'h55);
      sb[0].push_back(pdata);
      cyc();
      pv = 1'b0;
    end
    pop0(2'd3);
    #1;
    chk("next_grant_ch", 64'(och), 64'd0);
    chk("next_grant_data", 64'(odata), 64'h60);
    pop0(2'd0); pop0(2'd0); pop0(2'd0);

    // concurrent push/pop on ch1
    push0(2'd1, 32'h20); push0(2'd1, 32'h21); push0(2'd1, 32'h22);
    #1;
    chk("cc_usage_before", 64'(u_of(usage, 1)), 64'd3);
    pv = 1'b1; pch = 2'd1; pdata = 32'h23; ordy = 1'b1;
    #1;
    chk("cc_ready", 64'(prdy), 64'd1);
    chk("cc_pop_ch", 64'(och), 64'd1);
    chk("cc_pop_data", 64'(odata), 64'(sb[1].pop_front()));
    sb[1].push_back(32'h23);
    cyc();
    pv = 1'b0; ordy = 1'b0;
    #1;
    chk("cc_usage_after", 64'(u_of(usage, 1)), 64'd3);
    pop0(2'd1); pop0(2'd1); pop0(2'd1);

    // fall-through on u1
    f_pv = 1'b1; f_pch = 2'd2; f_pdata = 32'h77; f_ordy = 1'b1;
    #1;
    chk("ft_valid", 64'(f_ov), 64'd1);
    chk("ft_ch", 64'(f_och), 64'd2);
    chk("ft_data", 64'(f_odata), 64'h77);
    cyc();
    f_pv = 1'b0; f_ordy = 1'b0;
    #1;
    chk("ft_usage", 64'(u_of(f_usage, 2)), 64'd0);
    chk("ft_empty", 64'(f_empty), 64'hF);
    chk("ft_valid_after", 64'(f_ov), 64'd0);
    f_pv = 1'b1; f_pch = 2'd1; f_pdata = 32'h78;
    #1;
    chk("ft_nopop_data", 64'(f_odata), 64'h78);
    cyc();
    f_pv = 1'b0;
    #1;
    chk("ft_locked_ch", 64'(f_och), 64'd1);
    chk("ft_locked_data", 64'(f_odata), 64'h78);
    chk("ft_stored_usage", 64'(u_of(f_usage, 1)), 64'd1);
    f_ordy = 1'b1;
    cyc();
    f_ordy = 1'b0;
    #1;
    chk("ft_drained", 64'(f_empty), 64'hF);

    // flush while granted
    for (int i = 0; i < 5; i++) push0(2'd1, 32'h30 + 32'(i));
    push0(2'd3, 32'h40);
    #1;
    chk("fl_usage_before", 64'(u_of(usage, 1)), 64'd5);
    chk("fl_locked_ch", 64'(och), 64'd1);
    flush = 4'b0010; pch = 2'd1;
    #1;
    chk("fl_valid_drop", 64'(ov), 64'd0);
    chk("fl_push_blocked", 64'(prdy), 64'd0);
    cyc();
    flush = 4'b0000;
    sb[1].delete();
    #1;
    chk("fl_usage_after", 64'(u_of(usage, 1)), 64'd0);
    chk("fl_empty1", 64'(empty[1]), 64'd1);
    chk("fl_other_usage", 64'(u_of(usage, 3)), 64'd1);
    chk("fl_next_valid", 64'(ov), 64'd1);
    chk("fl_next_ch", 64'(och), 64'd3);
    chk("fl_next_data", 64'(odata), 64'h40);
`ifdef FIFO_V4_MC_PEAK_EN
    chk("fl_peak_clr", 64'(u_of(peak, 1)), 64'd0);
`endif

    // reset mid-operation with a held grant
    push0(2'd0, 32'h50); push0(2'd2, 32'h51);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) sb[c].delete();
    #1;
    chk("mr_empty", 64'(empty), 64'hF);
    chk("mr_valid", 64'(ov), 64'd0);
    chk("mr_usage", 64'(usage), 64'd0);
    chk("mr_rr", 64'(u0.rr_q), 64'd0);
    chk("mr_lock", 64'(u0.lock_q), 64'd0);
`ifdef FIFO_V4_MC_PEAK_EN
    chk("mr_peak", 64'(peak), 64'd0);
`endif
    push0(2'd2, 32'h99);
    pop0(2'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_v4_mc.md
Name: fifo_v4_mc

Overview:
- Parametrised multi-channel successor to the single-queue fifo_v3 used by the IOMMU request/response paths.
- Holds NUM_CH independent FIFO queues, each with its own storage, and one shared push port steered by channel id.
- A single pop port is fed by a round-robin arbiter over the non-empty channels, with a valid/ready handshake.
- Usage is exact (0..DEPTH inclusive), per-channel flush is supported, and a programmable almost-full watermark is provided.

Parameters:
- NUM_CH, 4, number of channels (>=1).
- DATA_WIDTH, 32, payload width.
- DEPTH, 8, entries per channel (>=1, any value, need not be a power of 2).
- FALL_THROUGH, 1'b0, empty-channel bypass from push to pop in the same cycle.
- AF_TH, DEPTH-1, almost-full threshold (1..DEPTH).
- CH_W, (NUM_CH>1)?$clog2(NUM_CH):1, derived; do not override.
- CNT_W, $clog2(DEPTH+1), derived; do not override.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- flush_i  in  NUM_CH  per-channel flush
- push_valid_i  in  1  push request
- push_ch_i  in  CH_W  target channel
- push_data_i  in  DATA_WIDTH  push payload
- push_ready_o  out  1  push accepted when valid & ready
- pop_valid_o  out  1  head available
- pop_ch_o  out  CH_W  channel of the presented head
- pop_data_o  out  DATA_WIDTH  head payload
- pop_ready_i  in  1  consumer accepts the head
- full_o  out  NUM_CH  usage==DEPTH
- empty_o  out  NUM_CH  usage==0
- almost_full_o  out  NUM_CH  usage>=AF_TH
- usage_o  out  NUM_CH*CNT_W  per-channel occupancy; channel c occupies bits [c*CNT_W +: CNT_W]

Behaviour:
- Reset (rst_i=1 at posedge): all pointers and usage cleared to 0, rr_q=0, lock_q=0.
  - Output values after reset: empty_o all 1; full_o, almost_full_o, pop_valid_o, push_ready_o all 0; pop_ch_o=0; pop_data_o=0.
  - Reset overrides every other input in the same cycle.
  - Reset mid-transfer discards all contents and any locked grant.
- Push:
  - push_ready_o = !full_o[push_ch_i] & !flush_i[push_ch_i] & !rst_i.
  - Purely combinational from the inputs; it does not depend on pop_ready_i.
  - A push to a full channel is never accepted, even if that channel is popped in the same cycle.
  - An accepted push writes mem[ch][wptr]. wptr advances next cycle and wraps from DEPTH-1 to 0.
- Pop arbitration:
  - Eligible channel: !empty & !flush_i[c].
  - When no grant is locked, grant = the first eligible channel searching upward from rr_q, modulo NUM_CH.
  - pop_valid_o = a grant exists. pop_data_o = head of the granted channel. pop_ch_o = the granted channel.
- Stability: if pop_valid_o & !pop_ready_i, then lock_q<=1 and the grant is held.
  - pop_ch_o and pop_data_o stay stable until the handshake completes.
  - New pushes into lower-priority channels do not perturb the held grant.
  - Exception: flush_i of the locked channel releases the lock, and pop_valid_o drops in that same cycle.
- Handshake (pop_valid_o & pop_ready_i):
  - Head is removed; rptr advances with wrap.
  - rr_q <= (granted ch + 1) mod NUM_CH.
  - lock_q <= 0.
- Usage per channel: next = usage + push_acc - pop_acc.
  - A push and a pop on the same channel in the same cycle leave usage unchanged.
  - Flags are registered from usage and are valid from the cycle after the update.
- FALL_THROUGH=1:
  - An empty channel receiving a push is eligible in the same cycle when no grant is locked; pop_data_o=push_data_i.
  - If popped in that cycle, the entry is not written and usage stays 0.
  - If not popped, the entry is written normally and the grant locks.
  - With FALL_THROUGH=0, pushed data is visible no earlier than the next cycle.
- Flush of channel c: pointers and usage for c clear next cycle. Any push to c and any pop from c in that cycle are blocked; other channels are unaffected.
- Latency:
  - FALL_THROUGH=0: 1 cycle from push to pop_valid_o for an idle, empty FIFO.
  - FALL_THROUGH=1: 0 cycles.

Optional Feature:
- Macro: FIFO_V4_MC_PEAK_EN.
- When defined:
  - Adds output peak_usage_o (NUM_CH*CNT_W): per-channel high-water mark.
  - Registered: peak <= max(peak, next usage).
  - Cleared by rst_i and by flush_i[c] for channel c.
- When undefined: the port and its registers are absent, and the remaining behaviour is identical.

Test Plan:
- Fill/watermark (DEPTH=8, AF_TH=7): reset, then push 0x10..0x17 into ch2 with pop_ready_i=0.
  - Expect almost_full_o[2]=1 after the 7th push and full_o[2]=1, usage_o[ch2]=8 after the 8th.
  - Expect push_ready_o=0 when push_ch_i=2, and 1 when push_ch_i=0.
- Round-robin: ch0 holds {0xA,0xB}, ch1 holds {0xC}, rr_q=0, pop_ready_i=1.
  - Expect pops (ch,data) = (0,A), (1,C), (0,B), then pop_valid_o=0 and empty_o=4'b1111.
- Stall stability: ch3 holds 0x55 and is granted; pop_ready_i=0 for 3 cycles while pushing into ch0.
  - Expect pop_ch_o=3 and pop_data_o=0x55 throughout.
  - After ready rises, the next grant is ch0.
- Concurrent push/pop: ch1 usage 3, push and pop ch1 in one cycle → usage stays 3 and FIFO order is preserved.
  - With FALL_THROUGH=1 and all channels empty, push 0x77 to ch2 with pop_ready_i=1 → same-cycle pop_data_o=0x77, usage_o[ch2] stays 0.
- Flush while granted: ch1 usage 5, locked grant, flush_i[1]=1.
  - Same cycle: pop_valid_o=0 for ch1.
  - Next cycle: usage_o[ch1]=0, empty_o[1]=1, and the arbiter presents the next eligible channel.
- Reset mid-operation: assert rst_i with several channels non-empty and a locked grant.
  - Next cycle: all empty, pop_valid_o=0, rr_q=0; peak_usage_o=0 if FIFO_V4_MC_PEAK_EN is defined.
